serial_link: RTL and testbench
==============================

SERIAL_LINK -- requirements
Module: serial_link

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 256, giving the payload bits per frame (minimum 2).
REQ-002 The block SHALL expose parameter DIV, default 4, giving the ser_clk_out half-period in clk cycles (minimum 1).
REQ-003 The block SHALL expose parameter PARITY_EN, default 1; when 1, one even-parity bit follows the payload.
REQ-004 The block SHALL expose parameter TIMEOUT, default 1024, giving the receive inter-edge timeout in clk cycles.
REQ-005 The block SHALL have one clock and asynchronous active-high reset: clk input 1 (sole clock), rst input 1 (async, active-high).
REQ-006 Ports SHALL be:
- start  in  1  request to send
- send_data  in  WIDTH  payload
- peer_ready  in  1  peer can accept
- ser_clk_out  out  1  serial clock
- ser_data_out  out  1  serial data
- ser_clk_in  in  1  async, from peer
- ser_data_in  in  1  async, from peer
- ready_out  out  1  receiver ready
- tx_busy  out  1  frame in progress
- tx_done  out  1  1-cycle pulse
- recv_data  out  WIDTH  last good or bad frame
- recv_valid  out  1  1-cycle pulse
- parity_err  out  1  frame error flag
- rx_timeout  out  1  1-cycle pulse

Function
REQ-007 Tx FSM SHALL have states IDLE, WAIT_PEER, SHIFT and DONE.
REQ-008 In IDLE, start=1 SHALL capture send_data into the shift register, compute parity = XOR of the payload, and go to WAIT_PEER the next cycle.
REQ-009 start SHALL be ignored whenever tx_busy=1; tx_busy=1 in every state except IDLE.
REQ-010 WAIT_PEER SHALL move to SHIFT on the first cycle peer_ready=1.
REQ-011 Bit period:
- Each bit SHALL occupy 2*DIV cycles.
- ser_data_out SHALL be updated while ser_clk_out is low.
- ser_clk_out SHALL be low for DIV cycles, then high for DIV cycles.
- The peer samples on the ser_clk_out rising edge.
REQ-012 Bit order SHALL be MSB first: WIDTH payload bits, then the parity bit if PARITY_EN=1.
REQ-013 If peer_ready falls mid-frame, the bit in progress SHALL complete; ser_clk_out SHALL then hold low and ser_data_out hold steady until peer_ready returns, then the next bit continues.
REQ-014 After the last bit's high phase, ser_clk_out SHALL return low, the FSM enters DONE, tx_done pulses for 1 cycle, and the FSM returns to IDLE.
REQ-015 Receive synchronisation:
- ser_clk_in and ser_data_in SHALL each pass through a 2-flop synchroniser.
- A sample SHALL be taken on each synchronised 0->1 edge of ser_clk_in.
REQ-016 Received bits SHALL shift in MSB first; a bit counter SHALL count to WIDTH+PARITY_EN.
REQ-017 On the final bit, recv_data SHALL load the payload, recv_valid pulses 1 cycle, and parity_err is set to (received parity != XOR of payload); the counter clears.
REQ-018 With PARITY_EN=0, parity_err SHALL stay 0.
REQ-019 parity_err SHALL hold until the next recv_valid or rst.
REQ-020 ready_out SHALL be 1 except during the single cycle recv_valid=1.
REQ-021 Timeout: if the bit counter is nonzero and no rising edge arrives for TIMEOUT cycles, the partial frame SHALL be discarded, the counter cleared, rx_timeout pulsed 1 cycle, and recv_data left unchanged.
REQ-022 Tx and Rx SHALL operate independently and simultaneously (full duplex, including loopback).

Reset
REQ-023 rst=1 SHALL asynchronously force:
- Tx FSM to IDLE.
- ser_clk_out, ser_data_out, tx_busy, tx_done, recv_valid, parity_err, rx_timeout = 0.
- recv_data = 0, ready_out = 1.
- Counters and synchronisers = 0.
REQ-024 rst asserted mid-frame SHALL abort both directions; no tx_done or recv_valid SHALL follow.

Verification
REQ-025 Use WIDTH=8, DIV=2, PARITY_EN=1 unless stated; loopback ser_clk_out->ser_clk_in, ser_data_out->ser_data_in, peer_ready=1. The bench SHALL cover:
- Basic loopback: send 8'hA5 -> 9 bits, each 4 cycles; tx_done pulses; recv_valid with recv_data=8'hA5, parity_err=0.
- Parity fault: inject a flipped parity bit on the frame 8'h3C -> recv_data=8'h3C, parity_err=1.
- Peer stall: drop peer_ready for 10 cycles after bit 3 -> ser_clk_out stays low for the gap; the received byte is still correct.
- Busy start: pulse start again during a frame with send_data=8'hFF -> ignored; only 8'hA5 is received.
- Timeout: drive 4 external rising edges then stop, with TIMEOUT=16 -> rx_timeout pulses once; recv_data unchanged; a following full frame is received correctly.
- Reset: assert rst mid-frame -> all outputs at reset values immediately; no tx_done, no recv_valid.

Source files
------------

// File: rtl/serial_link.sv
// serial_link: full-duplex clock-forwarded serial link.
// Transmit side serialises a WIDTH-bit payload (MSB first, optional even
// parity bit appended) onto ser_clk_out/ser_data_out with flow control
// from peer_ready. Receive side synchronises ser_clk_in/ser_data_in,
// samples data on each rising edge of the forwarded clock and reports the
// frame, its parity status and inter-edge timeouts.
//
// Ports:
//   clk, rst          sole clock, async active-high reset
//   start, send_data  transmit request and payload
//   peer_ready        peer can accept bits
//   ser_clk_out       forwarded serial clock (low DIV, high DIV per bit)
//   ser_data_out      serial data, changes while ser_clk_out is low
//   ser_clk_in        serial clock from peer (asynchronous)
//   ser_data_in       serial data from peer (asynchronous)
//   ready_out         receiver ready, low only in the recv_valid cycle
//   tx_busy           frame in progress
//   tx_done           1-cycle pulse at end of frame
//   recv_data         last completed frame payload
//   recv_valid        1-cycle pulse when recv_data is updated
//   parity_err        parity status of the last frame
//   rx_timeout        1-cycle pulse when a partial frame is dropped
module serial_link #(
   parameter int unsigned WIDTH     = 256,
   parameter int unsigned DIV       = 4,
   parameter int unsigned PARITY_EN = 1,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] send_data,
   input  logic             peer_ready,
   output logic             ser_clk_out,
   output logic             ser_data_out,
   input  logic             ser_clk_in,
   input  logic             ser_data_in,
   output logic             ready_out,
   output logic             tx_busy,
   output logic             tx_done,
   output logic [WIDTH-1:0] recv_data,
   output logic             recv_valid,
   output logic             parity_err,
   output logic             rx_timeout
);

   localparam int unsigned NBITS = WIDTH + PARITY_EN;
   localparam int unsigned BCW   = $clog2(NBITS + 1);
   localparam int unsigned PCW   = $clog2(2 * DIV);
   localparam int unsigned TCW   = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_PEER = 2'd1,
      SHIFT     = 2'd2,
      DONE      = 2'd3
   } tx_state_t;

   // ---------------------------------------------------------------
   // Transmit
   // ---------------------------------------------------------------
   tx_state_t        tx_state;
   logic [WIDTH:0]   tx_sr;       // payload followed by its parity bit
   logic [BCW-1:0]   tx_bit_cnt;  // bits fully sent in this frame
   logic [PCW-1:0]   phase_cnt;   // position inside the current bit

   // Bit timing: phase 0..DIV-1 clock low, DIV..2*DIV-1 clock high.
   // WAIT_PEER doubles as the mid-frame stall state: clock held low,
   // data held steady until peer_ready returns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state     <= IDLE;
         tx_sr        <= '0;
         tx_bit_cnt   <= '0;
         phase_cnt    <= '0;
         ser_clk_out  <= 1'b0;
         ser_data_out <= 1'b0;
         tx_busy      <= 1'b0;
         tx_done      <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (tx_state)
            IDLE: begin
               if (start) begin
                  tx_sr      <= {send_data, ^send_data};
                  tx_bit_cnt <= '0;
                  tx_busy    <= 1'b1;
                  tx_state   <= WAIT_PEER;
               end
            end
            WAIT_PEER: begin
               ser_clk_out <= 1'b0;
               if (peer_ready) begin
                  ser_data_out <= tx_sr[WIDTH];
                  tx_sr        <= {tx_sr[WIDTH-1:0], 1'b0};
                  phase_cnt    <= '0;
                  tx_state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (phase_cnt == PCW'(DIV - 1)) begin
                  ser_clk_out <= 1'b1;
                  phase_cnt   <= phase_cnt + 1'b1;
               end else if (phase_cnt == PCW'(2 * DIV - 1)) begin
                  // end of the high phase: bit complete
                  ser_clk_out <= 1'b0;
                  tx_bit_cnt  <= tx_bit_cnt + 1'b1;
                  if (tx_bit_cnt == BCW'(NBITS - 1)) begin
                     tx_done  <= 1'b1;
                     tx_state <= DONE;
                  end else if (peer_ready) begin
                     ser_data_out <= tx_sr[WIDTH];
                     tx_sr        <= {tx_sr[WIDTH-1:0], 1'b0};
                     phase_cnt    <= '0;
                  end else begin
                     tx_state <= WAIT_PEER;
                  end
               end else begin
                  phase_cnt <= phase_cnt + 1'b1;
               end
            end
            DONE: begin
               ser_data_out <= 1'b0;
               tx_busy      <= 1'b0;
               tx_state     <= IDLE;
            end
            default: begin
               tx_state <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Receive
   // ---------------------------------------------------------------
   logic [2:0]       clk_sync;   // [1:0] synchroniser, [2] edge history
   logic [1:0]       data_sync;
   logic [WIDTH-1:0] rx_sr;
   logic [BCW-1:0]   rx_cnt;
   logic [TCW-1:0]   to_cnt;     // cycles since last rising edge
   logic             rx_rise;
   logic             rx_d;
   logic [WIDTH-1:0] rx_shifted;

   always_comb begin
      rx_rise    = clk_sync[1] & ~clk_sync[2];
      rx_d       = data_sync[1];
      rx_shifted = {rx_sr[WIDTH-2:0], rx_d};
   end

   // Sample on synchronised rising edges; drop partial frames on timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync   <= '0;
         data_sync  <= '0;
         rx_sr      <= '0;
         rx_cnt     <= '0;
         to_cnt     <= '0;
         recv_data  <= '0;
         recv_valid <= 1'b0;
         parity_err <= 1'b0;
         rx_timeout <= 1'b0;
         ready_out  <= 1'b1;
      end else begin
         clk_sync   <= {clk_sync[1:0], ser_clk_in};
         data_sync  <= {data_sync[0], ser_data_in};
         recv_valid <= 1'b0;
         rx_timeout <= 1'b0;
         ready_out  <= 1'b1;
         if (rx_rise) begin
            to_cnt <= '0;
            if (rx_cnt == BCW'(NBITS - 1)) begin
               rx_cnt     <= '0;
               recv_valid <= 1'b1;
               ready_out  <= 1'b0;
               if (PARITY_EN != 0) begin
                  // payload already shifted in; this bit is the parity bit
                  recv_data  <= rx_sr;
                  parity_err <= rx_d ^ (^rx_sr);
               end else begin
                  recv_data  <= rx_shifted;
                  parity_err <= 1'b0;
               end
            end else begin
               rx_cnt <= rx_cnt + 1'b1;
               rx_sr  <= rx_shifted;
            end
         end else if (rx_cnt != '0) begin
            if (to_cnt == TCW'(TIMEOUT - 1)) begin
               rx_cnt     <= '0;
               to_cnt     <= '0;
               rx_timeout <= 1'b1;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end else begin
            to_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_serial_link.sv
// tb_serial_link: loopback bench for serial_link (WIDTH=8, DIV=2,
// PARITY_EN=1, TIMEOUT=16). Table of frames plus hand-written timeout
// and reset sequences.
module tb_serial_link;

   localparam int WIDTH_P   = 8;
   localparam int DIV_P     = 2;
   localparam int TIMEOUT_P = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] send_data;
   logic       peer_ready;
   logic       ser_clk_out;
   logic       ser_data_out;
   logic       ser_clk_in;
   logic       ser_data_in;
   logic       ready_out;
   logic       tx_busy;
   logic       tx_done;
   logic [7:0] recv_data;
   logic       recv_valid;
   logic       parity_err;
   logic       rx_timeout;

   logic ext_mode;
   logic ext_clk;
   logic ext_data;
   logic flip;

   int n_vec  = 0;
   int n_fail = 0;

   // loopback with optional parity-bit corruption or external driver
   assign ser_clk_in  = ext_mode ? ext_clk : ser_clk_out;
   assign ser_data_in = ext_mode ? ext_data : (ser_data_out ^ flip);

   serial_link #(
      .WIDTH(WIDTH_P), .DIV(DIV_P), .PARITY_EN(1), .TIMEOUT(TIMEOUT_P)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .send_data(send_data),
      .peer_ready(peer_ready), .ser_clk_out(ser_clk_out),
      .ser_data_out(ser_data_out), .ser_clk_in(ser_clk_in),
      .ser_data_in(ser_data_in), .ready_out(ready_out), .tx_busy(tx_busy),
      .tx_done(tx_done), .recv_data(recv_data), .recv_valid(recv_valid),
      .parity_err(parity_err), .rx_timeout(rx_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       flip_par;
      logic       stall;
      logic       poke;
      logic [7:0] exp_data;
      logic       exp_perr;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " ser_clk_out"},  32'(ser_clk_out),  32'(0));
      check({tag, " ser_data_out"}, 32'(ser_data_out), 32'(0));
      check({tag, " tx_busy"},      32'(tx_busy),      32'(0));
      check({tag, " tx_done"},      32'(tx_done),      32'(0));
      check({tag, " recv_valid"},   32'(recv_valid),   32'(0));
      check({tag, " parity_err"},   32'(parity_err),   32'(0));
      check({tag, " rx_timeout"},   32'(rx_timeout),   32'(0));
      check({tag, " recv_data"},    32'(recv_data),    32'(0));
      check({tag, " ready_out"},    32'(ready_out),    32'(1));
   endtask

   // Send one frame over the loopback and check timing and reception.
   task automatic run_frame(input vec_t v, input string tag);
      int rises = 0, txd = 0, rv = 0, gap = 0, hi = 0, cyc = 0, after = -1;
      int bad_gap = 0, bad_hi = 0, bad_stall = 0, bad_rdy = 0;
      int stall_left = 0, stall_el = 0, poke = 0, quiet = 0;
      logic prev, seen_busy = 1'b0, stalled = 1'b0, got_pe = 1'b0;
      logic [7:0] got_d = 8'h00;
      @(posedge clk); #1;
      send_data = v.data;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      prev  = ser_clk_out;
      while (cyc < 400 && after != 0) begin
         @(posedge clk); #1;
         cyc++;
         if (tx_busy) seen_busy = 1'b1;
         if (ser_clk_out && !prev) begin
            rises++;
            if (v.stall && rises == 4) begin
               if (gap < 10) bad_gap++;
            end else if (rises > 1 && gap != 2 * DIV_P) begin
               bad_gap++;
            end
            gap = 0;
         end
         if (ser_clk_out) hi++;
         else begin
            if (hi != 0 && hi != DIV_P) bad_hi++;
            hi = 0;
         end
         // stall: drop peer_ready in the high phase of bit 3
         if (v.stall && rises == 3 && !stalled) begin
            stalled    = 1'b1;
            peer_ready = 1'b0;
            stall_left = 10;
            stall_el   = 0;
         end else if (stall_left > 0) begin
            stall_left--;
            stall_el++;
            if (stall_el > DIV_P && ser_clk_out) bad_stall++;
            if (stall_left == 0) peer_ready = 1'b1;
         end
         // second start while busy
         if (v.poke && rises == 2 && poke == 0) begin
            send_data = 8'hFF;
            start     = 1'b1;
            poke      = 1;
         end else if (poke == 1) begin
            start = 1'b0;
            poke  = 2;
         end
         // corrupt the parity bit once bit 8 has been sampled
         if (v.flip_par && rises == 8 && gap == 2) flip = 1'b1;
         gap++;
         if (tx_done) txd++;
         if (recv_valid) begin
            rv++;
            got_d  = recv_data;
            got_pe = parity_err;
            if (ready_out) bad_rdy++;
         end else if (!ready_out) begin
            bad_rdy++;
         end
         prev = ser_clk_out;
         if (after < 0 && txd > 0 && rv > 0) after = 8;
         else if (after > 0) after--;
      end
      flip       = 1'b0;
      peer_ready = 1'b1;
      start      = 1'b0;
      check({tag, " rises"},      32'(rises),     32'(9));
      check({tag, " tx_done"},    32'(txd),       32'(1));
      check({tag, " recv_valid"}, 32'(rv),        32'(1));
      check({tag, " recv_data"},  32'(got_d),     32'(v.exp_data));
      check({tag, " parity_err"}, 32'(got_pe),    32'(v.exp_perr));
      check({tag, " bit_period"}, 32'(bad_gap),   32'(0));
      check({tag, " high_phase"}, 32'(bad_hi),    32'(0));
      check({tag, " ready_out"},  32'(bad_rdy),   32'(0));
      check({tag, " tx_busy"},    32'(seen_busy), 32'(1));
      if (v.stall) check({tag, " stall_low"}, 32'(bad_stall), 32'(0));
      // nothing else may be sent afterwards
      prev = ser_clk_out;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if ((ser_clk_out && !prev) || tx_busy) quiet++;
         prev = ser_clk_out;
      end
      check({tag, " idle_after"}, 32'(quiet), 32'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[8];
      vec_t v;
      int nto, nrv, lat, rises, txd, prev_c;
      vecs[0] = '{data: 8'hA5, flip_par: 0, stall: 0, poke: 0, exp_data: 8'hA5, exp_perr: 0};
      vecs[1] = '{data: 8'h3C, flip_par: 1, stall: 0, poke: 0, exp_data: 8'h3C, exp_perr: 1};
      vecs[2] = '{data: 8'hA5, flip_par: 0, stall: 1, poke: 0, exp_data: 8'hA5, exp_perr: 0};
      vecs[3] = '{data: 8'hA5, flip_par: 0, stall: 0, poke: 1, exp_data: 8'hA5, exp_perr: 0};
      vecs[4] = '{data: 8'h00, flip_par: 0, stall: 0, poke: 0, exp_data: 8'h00, exp_perr: 0};
      vecs[5] = '{data: 8'hFF, flip_par: 0, stall: 0, poke: 0, exp_data: 8'hFF, exp_perr: 0};
      vecs[6] = '{data: 8'h01, flip_par: 1, stall: 0, poke: 0, exp_data: 8'h01, exp_perr: 1};
      vecs[7] = '{data: 8'h80, flip_par: 0, stall: 0, poke: 0, exp_data: 8'h80, exp_perr: 0};

      rst = 1'b1; start = 1'b0; send_data = 8'h00; peer_ready = 1'b1;
      ext_mode = 1'b0; ext_clk = 1'b0; ext_data = 1'b0; flip = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 8; i++) begin
         run_frame(vecs[i], $sformatf("vec%0d", i));
      end

      // timeout: four external rising edges, then silence
      ext_mode = 1'b1;
      ext_data = 1'b1;
      for (int e = 0; e < 4; e++) begin
         ext_clk = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         ext_clk = 1'b1;
         if (e < 3) begin
            repeat (2) @(posedge clk);
            #1;
         end
      end
      nto = 0; nrv = 0; lat = -1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         if (k == 2) ext_clk = 1'b0;
         if (rx_timeout) begin
            nto++;
            if (nto == 1) lat = k;
         end
         if (recv_valid) nrv++;
      end
      check("timeout pulses",     32'(nto),       32'(1));
      check("timeout recv_valid", 32'(nrv),       32'(0));
      check("timeout recv_data",  32'(recv_data), 32'(8'h80));
      check("timeout latency_ok", 32'((lat >= TIMEOUT_P && lat <= TIMEOUT_P + 5) ? 1 : 0), 32'(1));
      ext_mode = 1'b0;
      ext_clk  = 1'b0;
      repeat (2) @(posedge clk);

      v = '{data: 8'h5A, flip_par: 0, stall: 0, poke: 0, exp_data: 8'h5A, exp_perr: 0};
      run_frame(v, "post_timeout");
      v = '{data: 8'h3C, flip_par: 1, stall: 0, poke: 0, exp_data: 8'h3C, exp_perr: 1};
      run_frame(v, "pre_reset");

      // reset in the middle of a frame
      @(posedge clk); #1;
      send_data = 8'hA5;
      start     = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      rises  = 0;
      prev_c = 0;
      for (int k = 0; k < 100 && rises < 4; k++) begin
         @(posedge clk); #1;
         if (ser_clk_out && prev_c == 0) rises++;
         prev_c = int'(ser_clk_out);
      end
      check("midframe reached", 32'(rises), 32'(4));
      #2;
      rst = 1'b1;
      #1;
      check_reset_vals("midreset");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      rises = 0; txd = 0; nrv = 0; prev_c = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (ser_clk_out && prev_c == 0) rises++;
         if (tx_done) txd++;
         if (recv_valid) nrv++;
         prev_c = int'(ser_clk_out);
      end
      check("after_reset rises",      32'(rises), 32'(0));
      check("after_reset tx_done",    32'(txd),   32'(0));
      check("after_reset recv_valid", 32'(nrv),   32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
